lut_product_arbiter: RTL and testbench

//  Shares one programmable lookup table of product records {X, Y} between NREQ requesters.
//  - Round-robin arbitration, one lookup accepted per cycle.
//  - Registered response with valid/ready handshake, tagged with the requester id.
//  - Runtime config write port rewrites table entries.
//  - Sits in front of LUT-decoded control fields; replaces one hard LUT per consumer.

---
 rtl/lut_product_arbiter.sv | 145 ++++++++++++++
 tb/tb_lut_product_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_product_arbiter.sv
// lut_product_arbiter
//   Shares one programmable lookup table of {X, Y} product records between
//   NREQ requesters. Round-robin arbitration accepts at most one lookup per
//   cycle. The response is held in a single registered slot with a
//   valid/ready handshake and is tagged with the id of the granted requester.
//   A config write port rewrites table entries at runtime. A config write
//   blocks any grant in the same cycle.
//
// Ports
//   CLK, ASYNCRESET       clock (rising edge), async active-high reset
//   req_valid/req_addr    per-requester lookup request and address
//   req_ready             combinational one-hot (or zero) grant
//   rsp_valid/rsp_ready   response slot handshake
//   rsp_X/rsp_Y/rsp_id    looked-up record and granted requester index
//   cfg_we/cfg_addr/
//   cfg_X/cfg_Y           table write port
//   lookup_cnt            saturating count of accepted lookups
//                         (present only when LUT_ARB_STATS_EN is defined)
//   busy                  mirrors rsp_valid
//
// Optional feature macro: LUT_ARB_STATS_EN

module lut_product_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 1,
  parameter int unsigned Y_W    = 2,
  parameter logic [(2**ADDR_W)*(1+Y_W)-1:0] INIT = 6'h1E,
  localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_X,
  output logic [Y_W-1:0]           rsp_Y,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic                     cfg_X,
  input  logic [Y_W-1:0]           cfg_Y,
`ifdef LUT_ARB_STATS_EN
  output logic [15:0]              lookup_cnt,
`endif
  output logic                     busy
);

  localparam int unsigned EW    = 1 + Y_W;
  localparam int unsigned DEPTH = 2**ADDR_W;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic            state_q, state_d;
  logic [EW-1:0]   table_q [DEPTH];
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            can_accept;
  logic            accept;
  logic [ADDR_W-1:0] win_addr;
  logic [EW-1:0]   win_entry;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NREQ
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Address of the winning requester
  always_comb begin
    win_addr = '0;
    for (int r = 0; r < int'(NREQ); r++) begin
      if (ID_W'(r) == winner) win_addr = req_addr[r*ADDR_W +: ADDR_W];
    end
  end

  assign win_entry  = table_q[win_addr];
  assign can_accept = !cfg_we && ((state_q == ST_EMPTY) || rsp_ready);
  assign accept     = found && can_accept && !ASYNCRESET;

  // Grant is held low during reset through the accept term
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Response slot next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Slot, pointer, response payload and table storage
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      rsp_X    <= 1'b0;
      rsp_Y    <= '0;
      rsp_id   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= INIT[i*EW +: EW];
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr_q <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
        rsp_X    <= win_entry[EW-1];
        rsp_Y    <= win_entry[Y_W-1:0];
        rsp_id   <= winner;
      end
      // No lookup is accepted while cfg_we is high, so no read/write race
      if (cfg_we) table_q[cfg_addr] <= {cfg_X, cfg_Y};
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign busy      = rsp_valid;

`ifdef LUT_ARB_STATS_EN
  // Saturating accepted-lookup counter
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      lookup_cnt <= '0;
    end else if (accept && (lookup_cnt != 16'hFFFF)) begin
      lookup_cnt <= lookup_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_product_arbiter.sv
// Self-checking bench for lut_product_arbiter: directed vector table,
// hand-written reset sequences and randomized traffic against a
// behavioural model of the table, slot and round-robin pointer.
module tb_lut_product_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 1;
  localparam int Y_W    = 2;

  logic                   CLK;
  logic                   ASYNCRESET;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_X;
  logic [Y_W-1:0]         rsp_Y;
  logic                   rsp_id;
  logic                   cfg_we;
  logic [ADDR_W-1:0]      cfg_addr;
  logic                   cfg_X;
  logic [Y_W-1:0]         cfg_Y;
  logic                   busy;
`ifdef LUT_ARB_STATS_EN
  logic [15:0]            lookup_cnt;
`endif

  lut_product_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .Y_W(Y_W), .INIT(6'h1E)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_X      (rsp_X),
    .rsp_Y      (rsp_Y),
    .rsp_id     (rsp_id),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_X      (cfg_X),
    .cfg_Y      (cfg_Y),
`ifdef LUT_ARB_STATS_EN
    .lookup_cnt (lookup_cnt),
`endif
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [2:0] m_table [2];
  int         m_ptr;
  bit         m_full;
  int         m_x, m_y, m_id;
  int         m_cnt;

  // Values sampled in the most recent step
  int s_ready, s_valid, s_x, s_y, s_id;

  typedef struct {
    logic [1:0] v;
    logic [1:0] a;
    logic       rr;
    logic       we;
    logic       ca;
    logic       cx;
    logic [1:0] cy;
    logic [1:0] e_ready;
    logic       e_valid;
    logic       e_x;
    logic [1:0] e_y;
    logic       e_id;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_table[0] = 3'b110;
    m_table[1] = 3'b011;
    m_ptr  = 0;
    m_full = 0;
    m_cnt  = 0;
  endtask

  // One clock cycle: drive, sample at negedge, compare with model, advance model
  task automatic step(input logic [1:0] v, input logic [1:0] a, input logic rr,
                      input logic we, input logic ca, input logic cx, input logic [1:0] cy);
    bit found;
    int w;
    bit can;
    logic [1:0] e_ready;
    logic [2:0] ent;
    req_valid = v; req_addr = a; rsp_ready = rr;
    cfg_we = we; cfg_addr = ca; cfg_X = cx; cfg_Y = cy;
    @(negedge CLK);
    s_ready = int'(req_ready); s_valid = int'(rsp_valid);
    s_x = int'(rsp_X); s_y = int'(rsp_Y); s_id = int'(rsp_id);
    can = !we && (!m_full || rr);
    found = 0; w = 0;
    for (int k = 0; k < NREQ; k++) begin
      int r;
      r = (m_ptr + k) % NREQ;
      if (!found && v[r]) begin found = 1; w = r; end
    end
    e_ready = (found && can) ? 2'(1 << w) : 2'b00;
    chk("req_ready", s_ready, int'(e_ready));
    chk("rsp_valid", s_valid, int'(m_full));
    chk("busy", int'(busy), int'(m_full));
    if (m_full) begin
      chk("rsp_X", s_x, m_x);
      chk("rsp_Y", s_y, m_y);
      chk("rsp_id", s_id, m_id);
    end
`ifdef LUT_ARB_STATS_EN
    chk("lookup_cnt", int'(lookup_cnt), m_cnt);
`endif
    @(posedge CLK);
    #1;
    if (found && can) begin
      ent    = m_table[a[w*ADDR_W +: ADDR_W]];
      m_x    = int'(ent[2]);
      m_y    = int'(ent[1:0]);
      m_id   = w;
      m_full = 1;
      m_ptr  = (w + 1) % NREQ;
      if (m_cnt < 65535) m_cnt++;
    end else if (rr) begin
      m_full = 0;
    end
    if (we) m_table[ca] = {cx, cy};
  endtask

  initial begin
    // v, a, rr, we, ca, cx, cy | e_ready, e_valid, e_x, e_y, e_id
    vecs[0]  = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0};
    vecs[2]  = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[4]  = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b11, 1'b0};
    vecs[5]  = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[6]  = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b11, 1'b0};
    vecs[7]  = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[8]  = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[9]  = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[10] = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[11] = '{2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0};
    vecs[12] = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[13] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0};

    m_x = 0; m_y = 0; m_id = 0;
    model_reset();

    // Reset state, grant suppressed while reset is high
    ASYNCRESET = 1'b1;
    req_valid = 2'b11; req_addr = 2'b00; rsp_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = 1'b0; cfg_X = 1'b0; cfg_Y = 2'b00;
    #12;
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_X", int'(rsp_X), 0);
    chk("reset_rsp_Y", int'(rsp_Y), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    req_valid = 2'b00;
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    @(posedge CLK);
    #1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].v, vecs[i].a, vecs[i].rr, vecs[i].we, vecs[i].ca, vecs[i].cx, vecs[i].cy);
      chk($sformatf("vec%0d_ready", i), s_ready, int'(vecs[i].e_ready));
      chk($sformatf("vec%0d_valid", i), s_valid, int'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_X", i), s_x, int'(vecs[i].e_x));
        chk($sformatf("vec%0d_Y", i), s_y, int'(vecs[i].e_y));
        chk($sformatf("vec%0d_id", i), s_id, int'(vecs[i].e_id));
      end
    end

    // Reset asserted mid-cycle while the slot is full
    step(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    req_valid = 2'b11;
    #2;
    ASYNCRESET = 1'b1;
    #1;
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    model_reset();
    req_valid = 2'b00;
    @(posedge CLK);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    @(posedge CLK);
    #1;
    step(2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("postrst_grant", s_ready, 1);
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("postrst_X", s_x, 0);
    chk("postrst_Y", s_y, 3);
    chk("postrst_id", s_id, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
